// File: rtl/snake_ps2_pkg.sv
// Shared constants for the snake arrow-key decoder: scan codes, direction
// encodings, prefix FSM states and the reverse-move helper.
package snake_ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'b000,
    DIR_UP    = 3'b001,
    DIR_LEFT  = 3'b010,
    DIR_DOWN  = 3'b011,
    DIR_RIGHT = 3'b100,
    DIR_HALT  = 3'b111
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_state_t;

  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a == DIR_UP    && b == DIR_DOWN)  ||
           (a == DIR_DOWN  && b == DIR_UP)    ||
           (a == DIR_LEFT  && b == DIR_RIGHT) ||
           (a == DIR_RIGHT && b == DIR_LEFT);
  endfunction

  // Non-arrow codes map to DIR_NONE so the caller can test for "is an arrow".
  function automatic dir_t arrow_dir(input logic [7:0] code);
    case (code)
      SC_UP:    return DIR_UP;
      SC_LEFT:  return DIR_LEFT;
      SC_DOWN:  return DIR_DOWN;
      SC_RIGHT: return DIR_RIGHT;
      default:  return DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/snake_dir_decoder_queue.sv
// Small synchronous FIFO of directions; a pop and a push may share a cycle
// even when full, and flush empties it unconditionally.
module dir_queue
  import snake_ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  dir_t                       din,
  output dir_t                       head,
  output dir_t                       tail,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dir_t           mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  tail_ptr;
  logic           push_ok;
  logic           pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_ok   = pop && !empty && !flush;
  assign push_ok  = push && !flush && (!full || pop_ok);
  assign tail_ptr = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - 1'b1;
  assign head     = mem[rd_ptr];
  assign tail     = mem[tail_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/snake_dir_decoder.sv
// PS/2 set-2 arrow-key decoder for the snake game: prefix FSM, legal-move
// filter and a short move queue drained one entry per game step.
//
// state      | meaning
// -----------+---------------------------------------------
// ST_IDLE    | no prefix pending; bytes are plain make codes
// ST_EXT     | E0 seen; next byte is an extended make code
// ST_BRK     | F0 seen; next byte is a released key, ignored
// ST_EXT_BRK | E0 F0 seen; next byte is a released key, ignored
module snake_dir_decoder
  import snake_ps2_pkg::*;
#(
  parameter int QUEUE_DEPTH   = 4,
  parameter int REQUIRE_E0    = 0,
  parameter int ALLOW_REVERSE = 0
) (
  input  logic                             VGA_clk,
  input  logic                             reset,
  input  logic [7:0]                       rx_data,
  input  logic                             rx_valid,
  input  logic                             step,
  input  logic                             halt,
  output logic [2:0]                       direction,
  output logic                             game_reset,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] q_count,
  output logic                             drop
);

  ps2_state_t state;
  ps2_state_t state_next;
  logic       make_seen;
  logic       make_ext;

  dir_t dir_q;
  dir_t cand_dir;
  dir_t ref_dir;
  dir_t q_head;
  dir_t q_tail;
  logic q_full;
  logic q_empty;
  logic halt_q;
  logic cand_valid;
  logic cand_legal;
  logic accept;
  logic push;
  logic pop;
  logic drop_next;
  logic space_hit;

  always_ff @(posedge VGA_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    make_seen  = 1'b0;
    make_ext   = 1'b0;
    if (rx_valid) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == SC_EXT)      state_next = ST_EXT;
          else if (rx_data == SC_BRK) state_next = ST_BRK;
          else                        make_seen  = 1'b1;
        end
        ST_EXT: begin
          if (rx_data == SC_BRK)      state_next = ST_EXT_BRK;
          else if (rx_data == SC_EXT) state_next = ST_EXT;
          else begin
            make_seen  = 1'b1;
            make_ext   = 1'b1;
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // NONE/HALT references never match or reverse a real arrow, so they admit anything.
  assign cand_dir   = arrow_dir(rx_data);
  assign cand_valid = make_seen && (cand_dir != DIR_NONE) && (make_ext || REQUIRE_E0 == 0);
  assign ref_dir    = q_empty ? dir_q : q_tail;
  assign cand_legal = (cand_dir != ref_dir) &&
                      (ALLOW_REVERSE != 0 || !is_reverse(ref_dir, cand_dir));
  assign accept     = cand_valid && cand_legal && !halt;
  assign pop        = step && !halt && !q_empty;
  assign push       = accept && (!q_full || pop);
  assign drop_next  = accept && q_full && !pop;
  assign space_hit  = make_seen && !make_ext && (rx_data == SC_SPACE) && halt;

  dir_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk   (VGA_clk),
    .reset (reset),
    .flush (halt),
    .push  (push),
    .pop   (pop),
    .din   (cand_dir),
    .head  (q_head),
    .tail  (q_tail),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      dir_q      <= DIR_NONE;
      halt_q     <= 1'b0;
      game_reset <= 1'b0;
      drop       <= 1'b0;
    end else begin
      halt_q     <= halt;
      game_reset <= space_hit;
      drop       <= drop_next;
      if (halt)        dir_q <= DIR_HALT;
      else if (halt_q) dir_q <= DIR_NONE;
      else if (pop)    dir_q <= q_head;
    end
  end

  assign direction = dir_q;

endmodule

// File: tb/tb_snake_dir_decoder.sv
// Directed bench for snake_dir_decoder; four parameter variants share one
// input stream and each phase checks the variant it targets.
module tb_snake_dir_decoder;

  logic       VGA_clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       step;
  logic       halt;

  logic [2:0] dir_a, dir_b, dir_c, dir_d;
  logic       grst_a, grst_b, grst_c, grst_d;
  logic       drop_a, drop_b, drop_c, drop_d;
  logic [2:0] qc_a, qc_c, qc_d;
  logic [1:0] qc_b;

  int checks   = 0;
  int failures = 0;

  always #5 VGA_clk = ~VGA_clk;

  snake_dir_decoder dut_a (
    .VGA_clk(VGA_clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .step(step), .halt(halt), .direction(dir_a), .game_reset(grst_a),
    .q_count(qc_a), .drop(drop_a));

  snake_dir_decoder #(.QUEUE_DEPTH(2)) dut_b (
    .VGA_clk(VGA_clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .step(step), .halt(halt), .direction(dir_b), .game_reset(grst_b),
    .q_count(qc_b), .drop(drop_b));

  snake_dir_decoder #(.REQUIRE_E0(1)) dut_c (
    .VGA_clk(VGA_clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .step(step), .halt(halt), .direction(dir_c), .game_reset(grst_c),
    .q_count(qc_c), .drop(drop_c));

  snake_dir_decoder #(.ALLOW_REVERSE(1)) dut_d (
    .VGA_clk(VGA_clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .step(step), .halt(halt), .direction(dir_d), .game_reset(grst_d),
    .q_count(qc_d), .drop(drop_d));

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge VGA_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_ext(input logic [7:0] b);
    send(8'hE0);
    send(b);
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    step     = 1'b0;
    halt     = 1'b0;

    // reset with a byte strobed in: it must be discarded
    rx_data  = 8'h75;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    do_reset();
    check_val("rst_dir", dir_a, 8'd0);
    check_val("rst_qc", qc_a, 8'd0);
    check_val("rst_drop", drop_a, 8'd0);
    check_val("rst_grst", grst_a, 8'd0);

    // 1: extended UP queued, then applied on step
    send_ext(8'h75);
    check_val("t1_qc_push", qc_a, 8'd1);
    check_val("t1_dir_before_step", dir_a, 8'd0);
    do_step();
    check_val("t1_dir_up", dir_a, 8'd1);
    check_val("t1_qc_pop", qc_a, 8'd0);

    // 2: reverse and same-direction rejection against direction and tail
    send_ext(8'h72);
    check_val("t2_down_rejected", qc_a, 8'd0);
    check_val("t2_d_down_allowed", qc_d, 8'd1);
    send_ext(8'h6B);
    check_val("t2_left_queued", qc_a, 8'd1);
    send_ext(8'h74);
    check_val("t2_right_vs_tail", qc_a, 8'd1);
    send_ext(8'h6B);
    check_val("t2_same_as_tail", qc_a, 8'd1);
    check_val("t2_d_all_queued", qc_d, 8'd4);
    do_step();
    check_val("t2_dir_left", dir_a, 8'd2);
    check_val("t2_d_dir_down", dir_d, 8'd3);

    // 3: break sequences push nothing and return the FSM to idle
    do_reset();
    send(8'hE0); send(8'hF0); send(8'h75);
    check_val("t3_ext_break", qc_a, 8'd0);
    send(8'hF0); send(8'h74);
    check_val("t3_plain_break", qc_a, 8'd0);
    send_ext(8'h74);
    check_val("t3_after_break", qc_a, 8'd1);

    // 4: depth-2 overflow drops once; coincident step frees the slot
    do_reset();
    send_ext(8'h75);
    send_ext(8'h6B);
    check_val("t4_qc_two", qc_b, 8'd2);
    send_ext(8'h72);
    check_val("t4_qc_full", qc_b, 8'd2);
    check_val("t4_drop_pulse", drop_b, 8'd1);
    tick();
    check_val("t4_drop_clear", drop_b, 8'd0);
    do_reset();
    send_ext(8'h75);
    send_ext(8'h6B);
    send(8'hE0);
    rx_data  = 8'h72;
    rx_valid = 1'b1;
    step     = 1'b1;
    tick();
    rx_valid = 1'b0;
    step     = 1'b0;
    check_val("t4_coinc_qc", qc_b, 8'd2);
    check_val("t4_coinc_drop", drop_b, 8'd0);
    check_val("t4_coinc_dir", dir_b, 8'd1);
    do_step();
    check_val("t4_pop_left", dir_b, 8'd2);
    do_step();
    check_val("t4_pop_down", dir_b, 8'd3);
    check_val("t4_empty", qc_b, 8'd0);

    // 5: bare make code depends on REQUIRE_E0
    do_reset();
    send(8'h75);
    check_val("t5_bare_req_e0", qc_c, 8'd0);
    check_val("t5_bare_default", qc_a, 8'd1);
    send_ext(8'h75);
    check_val("t5_ext_req_e0", qc_c, 8'd1);

    // 6: halt flushes, space restarts, release resets direction
    do_reset();
    send_ext(8'h75);
    do_step();
    send_ext(8'h6B);
    send_ext(8'h72);
    send_ext(8'h74);
    check_val("t6_qc_three", qc_a, 8'd3);
    send(8'h29);
    check_val("t6_space_no_halt", grst_a, 8'd0);
    halt = 1'b1;
    tick();
    check_val("t6_halt_dir", dir_a, 8'd7);
    check_val("t6_halt_flush", qc_a, 8'd0);
    send(8'h29);
    check_val("t6_grst_high", grst_a, 8'd1);
    tick();
    check_val("t6_grst_low", grst_a, 8'd0);
    do_step();
    check_val("t6_step_ignored", dir_a, 8'd7);
    send_ext(8'h74);
    check_val("t6_halt_discard", qc_a, 8'd0);
    check_val("t6_halt_no_drop", drop_a, 8'd0);
    halt = 1'b0;
    tick();
    check_val("t6_release_dir", dir_a, 8'd0);
    send_ext(8'h72);
    check_val("t6_down_accepted", qc_a, 8'd1);
    do_step();
    check_val("t6_dir_down", dir_a, 8'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
